// File: rtl/sumador_pkg.sv
// sumador_pkg: shared width default, op encoding and saturation helper
package sumador_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_W = 32;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  typedef struct packed {
    logic              ovf;
    logic [MAX_W-1:0]  val;
  } sat_t;
  function automatic sat_t sat_clamp(input logic signed [MAX_W:0] full, input int width);
    logic [MAX_W:0] one;
    logic signed [MAX_W:0] mx;
    logic signed [MAX_W:0] mn;
    sat_t r;
    one = 1;
    mx = (one << (width - 1)) - one;
    mn = ~mx;
    r.ovf = (full > mx) || (full < mn);
    r.val = full > mx ? mx[MAX_W-1:0] : full < mn ? mn[MAX_W-1:0] : full[MAX_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/sumador_core.sv
// sumador_core: combinational signed add/sub with full-precision and saturated results
module sumador_core import sumador_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH-1:0] sum_sat,
  output logic             ovf
);
  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] full;
  sat_t r;
  logic unused_val;
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    b_ext = {b[WIDTH-1], b};
    full = op_e'(sub) == OP_SUB ? a_ext - b_ext : a_ext + b_ext;
    r = sat_clamp((MAX_W+1)'(full), WIDTH);
    sum = full;
    sum_sat = r.val[WIDTH-1:0];
    ovf = r.ovf;
  end
  assign unused_val = ^r.val;
endmodule

// File: rtl/sumador_pipe.sv
// sumador_pipe: registered signed adder/subtractor with saturation and valid qualification
module sumador_pipe import sumador_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH-1:0] sum_sat,
  output logic             ovf
);
  logic [WIDTH:0]   core_sum;
  logic [WIDTH-1:0] core_sat;
  logic             core_ovf;
  logic             valid_d, valid_q;
  logic [WIDTH:0]   sum_d, sum_q;
  logic [WIDTH-1:0] sat_d, sat_q;
  logic             ovf_d, ovf_q;
  sumador_core #(.WIDTH(WIDTH)) u_core (
    .sub(sub),
    .a(a),
    .b(b),
    .sum(core_sum),
    .sum_sat(core_sat),
    .ovf(core_ovf)
  );
  always_comb begin
    valid_d = in_valid;
    sum_d = in_valid ? core_sum : sum_q;
    sat_d = in_valid ? core_sat : sat_q;
    ovf_d = in_valid ? core_ovf : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q <= '0;
      sat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q <= sum_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = valid_q;
  assign sum = sum_q;
  assign sum_sat = sat_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_sumador_pipe.sv
// tb_sumador_pipe: scoreboard bench for sumador_pipe
module tb_sumador_pipe;
  localparam int W = 8;
  localparam longint MAXV = 127;
  localparam longint MINV = -128;
  typedef struct {
    longint s;
    longint sat;
    longint ovf;
  } exp_t;
  logic clk = 0;
  logic rst, in_valid, sub;
  logic [W-1:0] a, b;
  logic out_valid;
  logic [W:0] sum;
  logic [W-1:0] sum_sat;
  logic ovf;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  longint last_s = 0, last_sat = 0, last_ovf = 0;
  sumador_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .sub(sub),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .sum(sum),
    .sum_sat(sum_sat),
    .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic s, input int av, input int bv);
    exp_t e;
    logic ev;
    rst = r;
    in_valid = v;
    sub = s;
    a = W'(av);
    b = W'(bv);
    ev = v && !r;
    if (ev) begin
      e.s = s ? longint'(av) - longint'(bv) : longint'(av) + longint'(bv);
      e.sat = e.s > MAXV ? MAXV : e.s < MINV ? MINV : e.s;
      e.ovf = (e.s > MAXV || e.s < MINV) ? 1 : 0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("out_valid", longint'(out_valid), longint'(ev));
    if (r) begin
      chk("rst_sum", longint'($signed(sum)), 0);
      chk("rst_sat", longint'($signed(sum_sat)), 0);
      chk("rst_ovf", longint'(ovf), 0);
      last_s = 0;
      last_sat = 0;
      last_ovf = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sum", longint'($signed(sum)), e.s);
        chk("sum_sat", longint'($signed(sum_sat)), e.sat);
        chk("ovf", longint'(ovf), e.ovf);
        last_s = e.s;
        last_sat = e.sat;
        last_ovf = e.ovf;
      end
    end else begin
      chk("hold_sum", longint'($signed(sum)), last_s);
      chk("hold_sat", longint'($signed(sum_sat)), last_sat);
      chk("hold_ovf", longint'(ovf), last_ovf);
    end
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 10, 20);
    step(0, 1, 0, -50, 75);
    step(0, 1, 0, -50, -50);
    step(0, 1, 0, 127, -127);
    step(0, 1, 0, 127, 127);
    step(0, 1, 0, -128, -128);
    step(0, 1, 1, -128, 127);
    step(0, 1, 1, 5, -3);
    step(0, 0, 1, 99, 99);
    step(0, 0, 0, -7, 3);
    step(0, 1, 1, 127, -128);
    step(0, 1, 1, -128, -128);
    step(0, 1, 0, -1, -127);
    step(0, 1, 1, -1, 127);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    step(0, 0, 0, 0, 0);
    chk("sb_drain", longint'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
